// File: rtl/coin_acceptor.sv
// Coin acceptor front end: accumulates coin credit, offers one purchase to the
// vending core over a valid/ready handshake, and refunds on cancel or inactivity.
module coin_acceptor #(
    parameter int MAX_CREDIT     = 15,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TMR_W          = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin_type,
    input  logic       item_sel_valid,
    input  logic [1:0] item_sel,
    input  logic       cancel,
    input  logic       vend_ready,
    output logic       vend_valid,
    output logic [3:0] deposited_amount,
    output logic [1:0] item_code,
    output logic       coin_reject,
    output logic       refund_valid,
    output logic [3:0] refund_amount,
    output logic [3:0] credit
);

    typedef enum logic [1:0] {IDLE, COLLECT, OFFER, REFUND} state_t;

    state_t             state, state_n;
    logic [TMR_W-1:0]   timer, timer_n;
    logic [3:0]         credit_n, deposited_n, refund_amount_n, coin_value;
    logic [1:0]         item_code_n;
    logic               vend_valid_n, coin_reject_n, refund_valid_n;
    logic [4:0]         sum;
    logic               fits, accepted;

    always_comb begin
        case (coin_type)
            2'b00:   coin_value = 4'd1;
            2'b01:   coin_value = 4'd2;
            2'b10:   coin_value = 4'd5;
            default: coin_value = 4'd10;
        endcase
        sum  = {1'b0, credit} + {1'b0, coin_value};
        fits = (sum <= 5'(MAX_CREDIT));
    end

    always_comb begin
        state_n         = state;
        timer_n         = timer;
        credit_n        = credit;
        item_code_n     = item_code;
        vend_valid_n    = vend_valid;
        deposited_n     = deposited_amount;
        coin_reject_n   = 1'b0;
        refund_valid_n  = 1'b0;
        refund_amount_n = 4'd0;
        accepted        = 1'b0;

        case (state)
            IDLE: begin
                timer_n = '0;
                if (coin_valid) begin
                    if (fits) begin
                        credit_n = sum[3:0];
                        state_n  = COLLECT;
                    end else begin
                        coin_reject_n = 1'b1;
                    end
                end
            end

            COLLECT: begin
                // The coin is folded in first so a same-cycle offer or refund carries it.
                if (coin_valid && fits) begin
                    credit_n = sum[3:0];
                    timer_n  = '0;
                    accepted = 1'b1;
                end else begin
                    coin_reject_n = coin_valid;
                    timer_n       = timer + TMR_W'(1);
                end

                if (cancel) begin
                    state_n         = REFUND;
                    timer_n         = '0;
                    refund_valid_n  = 1'b1;
                    refund_amount_n = credit_n;
                end else if (item_sel_valid) begin
                    state_n      = OFFER;
                    timer_n      = '0;
                    item_code_n  = item_sel;
                    vend_valid_n = 1'b1;
                    deposited_n  = credit_n;
                end else if (!accepted && timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n         = REFUND;
                    timer_n         = '0;
                    refund_valid_n  = 1'b1;
                    refund_amount_n = credit_n;
                end
            end

            OFFER: begin
                coin_reject_n = coin_valid;
                // A completed handshake takes precedence over a simultaneous cancel.
                if (vend_ready) begin
                    state_n      = IDLE;
                    vend_valid_n = 1'b0;
                    deposited_n  = 4'd0;
                    credit_n     = 4'd0;
                end else if (cancel) begin
                    state_n         = REFUND;
                    vend_valid_n    = 1'b0;
                    deposited_n     = 4'd0;
                    refund_valid_n  = 1'b1;
                    refund_amount_n = credit;
                end
            end

            REFUND: begin
                coin_reject_n = coin_valid;
                credit_n      = 4'd0;
                state_n       = IDLE;
            end

            default: begin
                state_n  = IDLE;
                credit_n = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            timer            <= '0;
            credit           <= 4'd0;
            item_code        <= 2'd0;
            vend_valid       <= 1'b0;
            deposited_amount <= 4'd0;
            coin_reject      <= 1'b0;
            refund_valid     <= 1'b0;
            refund_amount    <= 4'd0;
        end else begin
            state            <= state_n;
            timer            <= timer_n;
            credit           <= credit_n;
            item_code        <= item_code_n;
            vend_valid       <= vend_valid_n;
            deposited_amount <= deposited_n;
            coin_reject      <= coin_reject_n;
            refund_valid     <= refund_valid_n;
            refund_amount    <= refund_amount_n;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed and randomized bench for coin_acceptor against a cycle-level
// behavioural model of the credit / offer / refund rules.
module tb_coin_acceptor;

    localparam int TO  = 8;
    localparam int MAX = 15;

    localparam int P_IDLE    = 0;
    localparam int P_COLLECT = 1;
    localparam int P_OFFER   = 2;
    localparam int P_REFUND  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_type = 2'd0;
    logic       item_sel_valid = 1'b0;
    logic [1:0] item_sel = 2'd0;
    logic       cancel = 1'b0;
    logic       vend_ready = 1'b0;
    logic       vend_valid;
    logic [3:0] deposited_amount;
    logic [1:0] item_code;
    logic       coin_reject;
    logic       refund_valid;
    logic [3:0] refund_amount;
    logic [3:0] credit;

    int pass_count = 0;
    int check_count = 0;

    int m_phase, m_credit, m_idle, m_item;
    int exp_reject, exp_refund, exp_refund_amt;

    always #5 clk = ~clk;

    coin_acceptor #(
        .MAX_CREDIT    (MAX),
        .TIMEOUT_CYCLES(TO),
        .TMR_W         (7)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .coin_valid      (coin_valid),
        .coin_type       (coin_type),
        .item_sel_valid  (item_sel_valid),
        .item_sel        (item_sel),
        .cancel          (cancel),
        .vend_ready      (vend_ready),
        .vend_valid      (vend_valid),
        .deposited_amount(deposited_amount),
        .item_code       (item_code),
        .coin_reject     (coin_reject),
        .refund_valid    (refund_valid),
        .refund_amount   (refund_amount),
        .credit          (credit)
    );

    function automatic int coin_worth(input logic [1:0] t);
        int table_v[4] = '{1, 2, 5, 10};
        return table_v[t];
    endfunction

    task automatic modelReset();
        m_phase = P_IDLE;
        m_credit = 0;
        m_idle = 0;
        m_item = 0;
        exp_reject = 0;
        exp_refund = 0;
        exp_refund_amt = 0;
    endtask

    // One clock edge of the purchase rules, driven by the inputs present at that edge.
    task automatic modelStep();
        int w;
        bit took;
        w = coin_worth(coin_type);
        took = 0;
        exp_reject = 0;
        exp_refund = 0;
        exp_refund_amt = 0;
        case (m_phase)
            P_IDLE: begin
                if (coin_valid) begin
                    if (m_credit + w <= MAX) begin
                        m_credit += w;
                        m_idle = 0;
                        m_phase = P_COLLECT;
                    end else begin
                        exp_reject = 1;
                    end
                end
            end
            P_COLLECT: begin
                if (coin_valid) begin
                    if (m_credit + w <= MAX) begin
                        m_credit += w;
                        m_idle = 0;
                        took = 1;
                    end else begin
                        exp_reject = 1;
                    end
                end
                if (!took) m_idle++;
                if (cancel) begin
                    exp_refund = 1;
                    exp_refund_amt = m_credit;
                    m_phase = P_REFUND;
                end else if (item_sel_valid) begin
                    m_item = int'(item_sel);
                    m_phase = P_OFFER;
                end else if (m_idle == TO) begin
                    exp_refund = 1;
                    exp_refund_amt = m_credit;
                    m_phase = P_REFUND;
                end
            end
            P_OFFER: begin
                if (coin_valid) exp_reject = 1;
                if (vend_ready) begin
                    m_credit = 0;
                    m_phase = P_IDLE;
                end else if (cancel) begin
                    exp_refund = 1;
                    exp_refund_amt = m_credit;
                    m_phase = P_REFUND;
                end
            end
            default: begin
                if (coin_valid) exp_reject = 1;
                m_credit = 0;
                m_phase = P_IDLE;
            end
        endcase
    endtask

    task automatic checkVal(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        check_count++;
        assert (observed === expected) begin
            pass_count++;
        end else begin
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic checkOutput();
        bit offering;
        offering = (m_phase == P_OFFER);
        checkVal("vend_valid", 8'(vend_valid), 8'(offering));
        checkVal("deposited_amount", 8'(deposited_amount), offering ? 8'(m_credit) : 8'd0);
        checkVal("credit", 8'(credit), 8'(m_credit));
        checkVal("coin_reject", 8'(coin_reject), 8'(exp_reject));
        checkVal("refund_valid", 8'(refund_valid), 8'(exp_refund));
        checkVal("refund_amount", 8'(refund_amount), 8'(exp_refund_amt));
        if (offering) checkVal("item_code", 8'(item_code), 8'(m_item));
    endtask

    task automatic applyStimulus(input logic cv, input logic [1:0] ct, input logic iv,
                                 input logic [1:0] is, input logic cn, input logic vr);
        coin_valid = cv;
        coin_type = ct;
        item_sel_valid = iv;
        item_sel = is;
        cancel = cn;
        vend_ready = vr;
        @(posedge clk);
        modelStep();
        #1;
        checkOutput();
    endtask

    task automatic coin(input logic [1:0] ct);
        applyStimulus(1'b1, ct, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    endtask

    // Idles until refund_valid appears, returning how many cycles it took (0 if it never did).
    task automatic waitRefund(output int seen_at);
        seen_at = 0;
        for (int i = 1; i <= 20 && seen_at == 0; i++) begin
            idle(1);
            if (refund_valid) seen_at = i;
        end
    endtask

    initial begin
        int seen;
        modelReset();
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        reset = 1'b0;

        // Basic purchase: 5 + 2 + 1 then select item 1 with the core ready.
        coin(2'b10);
        coin(2'b01);
        coin(2'b00);
        checkVal("t1_credit", 8'(credit), 8'd8);
        applyStimulus(1'b0, 2'd0, 1'b1, 2'b01, 1'b0, 1'b1);
        checkVal("t1_offer_amount", 8'(deposited_amount), 8'd8);
        checkVal("t1_offer_item", 8'(item_code), 8'd1);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkVal("t1_done_valid", 8'(vend_valid), 8'd0);
        checkVal("t1_done_credit", 8'(credit), 8'd0);

        // Overflow boundary at MAX_CREDIT.
        coin(2'b11);
        coin(2'b11);
        checkVal("t2_reject", 8'(coin_reject), 8'd1);
        checkVal("t2_credit10", 8'(credit), 8'd10);
        coin(2'b10);
        checkVal("t2_credit15", 8'(credit), 8'd15);
        coin(2'b00);
        checkVal("t2_reject_full", 8'(coin_reject), 8'd1);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        checkVal("t2_refund15", 8'(refund_amount), 8'd15);
        idle(1);

        // Backpressure with a rejected coin while waiting.
        coin(2'b10);
        coin(2'b01);
        applyStimulus(1'b0, 2'd0, 1'b1, 2'b10, 1'b0, 1'b0);
        idle(1);
        coin(2'b00);
        checkVal("t3_wait_reject", 8'(coin_reject), 8'd1);
        idle(1);
        checkVal("t3_hold_amount", 8'(deposited_amount), 8'd7);
        checkVal("t3_hold_item", 8'(item_code), 8'd2);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        checkVal("t3_transfer", 8'(vend_valid), 8'd0);

        // Cancel from COLLECT, then cancel racing vend_ready in OFFER.
        coin(2'b10);
        coin(2'b01);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        checkVal("t4_refund7", 8'(refund_amount), 8'd7);
        idle(1);
        coin(2'b00);
        applyStimulus(1'b0, 2'd0, 1'b1, 2'b00, 1'b0, 1'b0);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b1);
        checkVal("t4_no_refund", 8'(refund_valid), 8'd0);
        idle(1);

        // Inactivity timeout, and a coin restarting the count.
        coin(2'b01);
        waitRefund(seen);
        checkVal("t5_timeout_cycles", 8'(seen), 8'(TO));
        idle(1);
        coin(2'b01);
        idle(4);
        coin(2'b00);
        waitRefund(seen);
        checkVal("t5_restart_cycles", 8'(seen), 8'(TO));
        idle(1);

        // Asynchronous reset in the middle of an offer.
        coin(2'b10);
        applyStimulus(1'b0, 2'd0, 1'b1, 2'b11, 1'b0, 1'b0);
        #3 reset = 1'b1;
        #1;
        modelReset();
        checkOutput();
        checkVal("t6_vend_valid", 8'(vend_valid), 8'd0);
        checkVal("t6_credit", 8'(credit), 8'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        idle(2);
        coin(2'b00);
        checkVal("t6_idle_credit", 8'(credit), 8'd1);
        applyStimulus(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0);
        idle(1);

        // Randomized traffic, busy first and then sparse enough for timeouts.
        for (int i = 0; i < 600; i++) begin
            int coin_pct;
            coin_pct = (i < 300) ? 35 : 6;
            applyStimulus($urandom_range(0, 99) < coin_pct, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 99) < 8, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 99) < 4, $urandom_range(0, 99) < 40);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
